// File: rtl/command_lookup.sv
// command_lookup: collects received bytes into a staging buffer and commits a
// complete message (on CR, or when 32 bytes have arrived) into a display buffer
// in a single cycle. The display buffer is read back through a registered,
// sel-indexed port that also serves the LCD line-address command bytes.
module command_lookup (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sel,
    input  logic [7:0] rx_data,
    input  logic       rx_data_rdy,
    output logic [7:0] data_out,
    output logic       buffer_ready
);

    localparam int         DEPTH     = 32;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_QMARK  = 8'h3F;
    localparam logic [7:0] LCD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_LINE2 = 8'hC0;

    logic [DEPTH-1:0][7:0] staging_q, staging_d;
    logic [DEPTH-1:0][7:0] display_q, display_d;
    logic [5:0]            wptr_q, wptr_d;
    logic [7:0]            data_out_q, data_out_d;
    logic                  buffer_ready_q, buffer_ready_d;

    logic       is_cr;
    logic       is_store;
    logic [7:0] store_byte;
    logic       commit;
    logic [5:0] commit_len;

    // Classify the incoming byte; non-printables are stored as '?'.
    always_comb begin
        is_cr      = rx_data_rdy && (rx_data == CH_CR);
        is_store   = rx_data_rdy && (rx_data != CH_CR) && (rx_data != CH_LF);
        store_byte = ((rx_data >= 8'h20) && (rx_data <= 8'h7E)) ? rx_data : CH_QMARK;
    end

    // Staging write, pointer update and commit into the display buffer.
    // The commit uses staging_d so a 32nd byte lands in the same commit.
    always_comb begin
        staging_d  = staging_q;
        display_d  = display_q;
        wptr_d     = wptr_q;
        commit     = 1'b0;
        commit_len = wptr_q;
        if (is_store) begin
            staging_d[wptr_q[4:0]] = store_byte;
            wptr_d                 = wptr_q + 6'd1;
            commit_len             = wptr_q + 6'd1;
            commit                 = (wptr_q >= 6'd31);
        end else if (is_cr) begin
            commit = 1'b1;
        end
        if (commit) begin
            for (int i = 0; i < DEPTH; i++) begin
                // Bytes at or past the write pointer are stale and never shown.
                display_d[i] = (6'(i) < commit_len) ? staging_d[i] : CH_SPACE;
            end
            wptr_d = 6'd0;
        end
        buffer_ready_d = commit;
    end

    // Read mux works off the pre-commit display so a same-edge commit is not seen yet.
    always_comb begin
        data_out_d = CH_SPACE;
        if (sel < 6'd32)       data_out_d = display_q[sel[4:0]];
        else if (sel == 6'd32) data_out_d = LCD_LINE1;
        else if (sel == 6'd33) data_out_d = LCD_LINE2;
    end

    // Control state and display buffer, cleared to spaces on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_q      <= {DEPTH{CH_SPACE}};
            wptr_q         <= 6'd0;
            data_out_q     <= CH_SPACE;
            buffer_ready_q <= 1'b0;
        end else begin
            display_q      <= display_d;
            wptr_q         <= wptr_d;
            data_out_q     <= data_out_d;
            buffer_ready_q <= buffer_ready_d;
        end
    end

    // Staging contents are only exposed below wptr, so they need no reset.
    always_ff @(posedge clk) begin
        staging_q <= staging_d;
    end

    assign data_out     = data_out_q;
    assign buffer_ready = buffer_ready_q;

endmodule

// File: tb/tb_command_lookup.sv
// Bench for command_lookup: directed scenarios plus a randomized byte stream,
// all checked against a queue-based message model.
module tb_command_lookup;

    logic       clk;
    logic       rst_n;
    logic [5:0] sel;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic [7:0] data_out;
    logic       buffer_ready;

    int tests_run;
    int tests_failed;
    int pulse_cnt;
    int exp_pulses;

    logic [7:0] mdisp [32];
    logic [7:0] mq [$];

    command_lookup dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel          (sel),
        .rx_data      (rx_data),
        .rx_data_rdy  (rx_data_rdy),
        .data_out     (data_out),
        .buffer_ready (buffer_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // buffer_ready is high for one full cycle, so each pulse is seen by exactly one edge.
    always @(posedge clk) if (rst_n && buffer_ready) pulse_cnt++;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mdisp[i] = 8'h20;
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < 32; i++) mdisp[i] = (i < mq.size()) ? mq[i] : 8'h20;
        mq.delete();
        exp_pulses++;
    endfunction

    // Returns 1 when this byte commits a message.
    function automatic bit model_rx(input logic [7:0] b);
        if (b == 8'h0D) begin
            model_commit();
            return 1'b1;
        end
        if (b == 8'h0A) return 1'b0;
        mq.push_back((b >= 8'h20 && b <= 8'h7E) ? b : 8'h3F);
        if (mq.size() == 32) begin
            model_commit();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] model_read(input int s);
        if (s < 32)  return mdisp[s];
        if (s == 32) return 8'h80;
        if (s == 33) return 8'hC0;
        return 8'h20;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        bit exp;
        rx_data     = b;
        rx_data_rdy = 1'b1;
        exp         = model_rx(b);
        @(negedge clk);
        rx_data_rdy = 1'b0;
        tests_run++;
        if (buffer_ready !== exp) begin
            tests_failed++;
            $display("FAIL buffer_ready after byte %h: got %b want %b", b, buffer_ready, exp);
        end
    endtask

    task automatic check_read(input int s);
        logic [7:0] exp;
        sel = 6'(s);
        exp = model_read(s);
        @(negedge clk);
        tests_run++;
        if (data_out !== exp) begin
            tests_failed++;
            $display("FAIL read sel=%0d: got %h want %h", s, data_out, exp);
        end
    endtask

    task automatic check_all_reads();
        for (int s = 0; s < 34; s++) check_read(s);
        check_read(0);
    endtask

    task automatic check_pulses(input string name);
        @(negedge clk);
        tests_run++;
        if (pulse_cnt !== exp_pulses) begin
            tests_failed++;
            $display("FAIL %s pulse count: got %0d want %0d", name, pulse_cnt, exp_pulses);
        end
    endtask

    task automatic check_in_reset(input string name);
        tests_run++;
        if (data_out !== 8'h20 || buffer_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s in reset: data_out=%h buffer_ready=%b want 20/0", name, data_out, buffer_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel = 6'd5;
        rx_data = 8'h00;
        rx_data_rdy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_in_reset("reset");
        rst_n = 1'b1;
        check_all_reads();
        check_pulses("reset");
    endtask

    task automatic test_hi();
        send_byte(8'h48);
        send_byte(8'h49);
        send_byte(8'h0D);
        check_all_reads();
        check_pulses("hi");
    endtask

    task automatic test_auto_commit();
        for (int i = 0; i < 32; i++) send_byte(8'h41);
        check_all_reads();
        send_byte(8'h42);
        send_byte(8'h0D);
        check_all_reads();
        check_pulses("auto_commit");
    endtask

    task automatic test_ctrl_bytes();
        send_byte(8'h07);
        send_byte(8'h0A);
        send_byte(8'h5A);
        send_byte(8'h0D);
        check_all_reads();
        check_pulses("ctrl_bytes");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h41);
        send_byte(8'h42);
        rst_n = 1'b0;
        @(negedge clk);
        check_in_reset("reset_mid");
        rst_n = 1'b1;
        model_reset();
        send_byte(8'h0D);
        check_all_reads();
        check_pulses("reset_mid");
    endtask

    task automatic test_read_during_commit();
        logic [7:0] old;
        sel = 6'd0;
        @(negedge clk);
        old = mdisp[0];
        send_byte(8'h5A);
        rx_data     = 8'h0D;
        rx_data_rdy = 1'b1;
        void'(model_rx(8'h0D));
        @(negedge clk);
        rx_data_rdy = 1'b0;
        tests_run++;
        if (data_out !== old || buffer_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_on_commit_edge: data_out=%h ready=%b want %h/1", data_out, buffer_ready, old);
        end
        @(negedge clk);
        tests_run++;
        if (data_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL read_after_commit: got %h want 5a", data_out);
        end
        check_pulses("read_during_commit");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 39);
            if (r == 0)      b = 8'h0D;
            else if (r == 1) b = 8'h0A;
            else if (r < 4)  b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 8'h1F)) : 8'($urandom_range(8'h7F, 8'hFF));
            else             b = 8'($urandom_range(8'h20, 8'h7E));
            if (b == 8'h0D && r != 0) b = 8'h3F;
            send_byte(b);
            if ($urandom_range(0, 3) == 0) begin
                sel = 6'($urandom_range(0, 63));
                @(negedge clk);
            end
            if (n % 80 == 79) begin
                check_all_reads();
                for (int k = 0; k < 4; k++) check_read(int'($urandom_range(34, 63)));
                check_pulses("random");
            end
        end
        send_byte(8'h0D);
        check_all_reads();
        check_pulses("random_end");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        pulse_cnt    = 0;
        exp_pulses   = 0;
        rst_n        = 1'b0;
        sel          = 6'd0;
        rx_data      = 8'h00;
        rx_data_rdy  = 1'b0;
        @(negedge clk);
        test_reset();
        test_hi();
        test_auto_commit();
        test_ctrl_bytes();
        test_reset_mid();
        test_read_during_commit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
